// File: rtl/mem_access_unit_if.sv
// Request/response port between the control FSM (master) and the load/store unit (slave).
// A request transfers on a rising edge where req_valid && req_ready; rsp_valid is a one-cycle strobe with no back-pressure.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32 load/store unit: request/response handshake, SRAM wait states, sub-word lanes,
// misalignment checks and a small memory-mapped I/O window (switches, LEDs, hex digits).
module mem_access_unit #(
  parameter int          ADDR_W      = 32,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00,
  parameter int          NUM_HEX     = 6,
  parameter int          SW_W        = 10,
  parameter int          LED_W       = 10
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  mem_access_unit_if.slave     bus,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [31:0]          sram_wdata,
  input  logic [31:0]          sram_rdata,
  output logic                 sram_oe,
  output logic                 sram_we,
  output logic [3:0]           sram_be,
  input  logic [SW_W-1:0]      SW,
  output logic [LED_W-1:0]     LED,
  output logic [4*NUM_HEX-1:0] hex_out,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [31:0]         wdata_q;
  logic                io_q;
  logic                err_q;
  logic [3:0]          cnt_q;
  logic [31:0]         rdata_q;
  logic [LED_W-1:0]    led_q;
  logic [4*NUM_HEX-1:0] hex_q;

  logic        accept;
  logic        acc_io;
  logic        acc_illegal;
  logic        acc_misal;
  logic        acc_err;
  logic        last_access;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] io_rdata;

  // Request decode happens at accept time so an erroring request never touches SRAM or I/O.
  always_comb begin
    accept      = bus.req_valid && (state == IDLE);
    acc_io      = (bus.req_addr[ADDR_W-1:8] == IO_BASE[ADDR_W-1:8]);
    acc_illegal = bus.req_we ? (bus.req_funct3 >= 3'd3)
                             : ((bus.req_funct3 == 3'd3) || (bus.req_funct3[2:1] == 2'b11));
    acc_misal   = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                  ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'b00));
    acc_err     = acc_illegal || acc_misal || (acc_io && (bus.req_funct3[1:0] != 2'd2));
    last_access = (state == ACCESS) && (cnt_q == 4'd0);
  end

  always_comb begin
    lane_be    = 4'hF;
    lane_wdata = wdata_q;
    if (we_q) begin
      case (f3_q[1:0])
        2'd0: begin
          lane_be    = 4'b0001 << addr_q[1:0];
          lane_wdata = {4{wdata_q[7:0]}};
        end
        2'd1: begin
          lane_be    = 4'b0011 << addr_q[1:0];
          lane_wdata = {2{wdata_q[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_byte = 8'(sram_rdata >> {addr_q[1:0], 3'b000});
    ld_half = addr_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    case (f3_q)
      3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_ext = {24'd0, ld_byte};
      3'd5:    ld_ext = {16'd0, ld_half};
      default: ld_ext = sram_rdata;
    endcase
    case (addr_q[7:0])
      8'h00:   io_rdata = 32'(SW);
      8'h04:   io_rdata = 32'(led_q);
      8'h08:   io_rdata = 32'(hex_q);
      default: io_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_rdata  = 32'd0;
    bus.rsp_err    = 1'b0;
    sram_oe        = 1'b0;
    sram_we        = 1'b0;
    sram_be        = 4'h0;
    sram_addr      = '0;
    sram_wdata     = 32'd0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = acc_err ? RESP : ACCESS;
      end
      ACCESS: begin
        if (!io_q) begin
          sram_oe    = !we_q;
          sram_we    = we_q;
          sram_be    = lane_be;
          sram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
          sram_wdata = we_q ? lane_wdata : 32'd0;
        end
        if (cnt_q == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load data and I/O register writes both land on the final ACCESS edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      wdata_q <= 32'd0;
      io_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      led_q   <= '0;
      hex_q   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        wdata_q <= bus.req_wdata;
        io_q    <= acc_io;
        err_q   <= acc_err;
        cnt_q   <= acc_io ? 4'd0 : 4'(WAIT_CYCLES);
        rdata_q <= 32'd0;
      end else if (state == ACCESS && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (last_access) begin
        if (!we_q) begin
          rdata_q <= io_q ? io_rdata : ld_ext;
        end else if (io_q) begin
          if (addr_q[7:0] == 8'h04) led_q <= wdata_q[LED_W-1:0];
          if (addr_q[7:0] == 8'h08) hex_q <= wdata_q[4*NUM_HEX-1:0];
        end
      end
    end
  end

  assign LED       = led_q;
  assign hex_out   = hex_q;
  assign state_dbg = state;

endmodule
